// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: drives the instruction memory request and loads the IF/ID register.
// Handles wait states, ID-stage freeze through a one-entry hold buffer, and branch redirects that drain an outstanding request.
module if_fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc_out,
    output logic [31:0] Instruction,
    output logic        if_valid
);

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]      state, state_d;
    logic [XLEN-1:0] pc, pc_d;
    logic [XLEN-1:0] drain_addr, drain_addr_d;
    logic [XLEN-1:0] hold_instr, hold_instr_d;
    logic [XLEN-1:0] hold_pc, hold_pc_d;
    logic            hold_valid, hold_valid_d;
    logic [XLEN-1:0] pc_out_d, instr_d;
    logic            if_valid_d;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] branch_target;
    logic            unused_branch_lsbs;

    // Redirect targets are forced word-aligned; the low bits carry no information.
    assign branch_target      = {branch_addr[XLEN-1:2], 2'b00};
    assign unused_branch_lsbs = ^branch_addr[1:0];
    assign pc_plus4           = pc + XLEN'(4);

    // While draining, the abandoned request keeps its address until memory completes it.
    assign imem_req  = ~rst & (state != HOLD);
    assign imem_addr = (state == DRAIN) ? drain_addr : pc;

    // State and IF/ID registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= '0;
            drain_addr  <= '0;
            hold_instr  <= '0;
            hold_pc     <= '0;
            hold_valid  <= 1'b0;
            pc_out      <= '0;
            Instruction <= '0;
            if_valid    <= 1'b0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            drain_addr  <= drain_addr_d;
            hold_instr  <= hold_instr_d;
            hold_pc     <= hold_pc_d;
            hold_valid  <= hold_valid_d;
            pc_out      <= pc_out_d;
            Instruction <= instr_d;
            if_valid    <= if_valid_d;
        end
    end

    // Next-state and next IF/ID contents
    always_comb begin
        state_d      = state;
        pc_d         = pc;
        drain_addr_d = drain_addr;
        hold_instr_d = hold_instr;
        hold_pc_d    = hold_pc;
        hold_valid_d = hold_valid;
        pc_out_d     = pc_out;
        instr_d      = Instruction;
        if_valid_d   = if_valid;

        if (branch_taken) begin
            // Branch beats freeze: flush IF/ID, drop the buffer and any same-cycle data.
            pc_d         = branch_target;
            pc_out_d     = '0;
            instr_d      = '0;
            if_valid_d   = 1'b0;
            hold_valid_d = 1'b0;
            if (state == FETCH && !imem_ready) begin
                state_d      = DRAIN;
                drain_addr_d = pc;
            end else if (state == DRAIN && !imem_ready) begin
                state_d = DRAIN;
            end else begin
                state_d = FETCH;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        pc_d = pc_plus4;
                        if (freeze) begin
                            hold_instr_d = imem_rdata;
                            hold_pc_d    = pc_plus4;
                            hold_valid_d = 1'b1;
                            state_d      = HOLD;
                        end else begin
                            instr_d    = imem_rdata;
                            pc_out_d   = pc_plus4;
                            if_valid_d = 1'b1;
                        end
                    end else if (!freeze) begin
                        pc_out_d   = '0;
                        instr_d    = '0;
                        if_valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!freeze) begin
                        instr_d      = hold_instr;
                        pc_out_d     = hold_pc;
                        if_valid_d   = hold_valid;
                        hold_valid_d = 1'b0;
                        state_d      = FETCH;
                    end
                end
                DRAIN: begin
                    if (!freeze) begin
                        pc_out_d   = '0;
                        instr_d    = '0;
                        if_valid_d = 1'b0;
                    end
                    if (imem_ready) begin
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

endmodule
